arith_result_buffer: RTL and testbench

Output buffer placed directly downstream of the pipelined arithmetic chain. It accepts the chain's 10-bit result stream, which is valid-qualified and has no backpressure, and stores results in a small first-word-fall-through FIFO. Results leave through a valid/ready handshake toward the consumer. Results that arrive while the buffer is full are dropped, and every drop is recorded in a sticky overflow flag and a saturating drop counter.

---
 rtl/arith_chain_pkg.sv | 19 +
 rtl/arith_result_buffer.sv | 111 +++++++++++
 tb/tb_arith_result_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/arith_chain_pkg.sv
// Shared definitions for the pipelined arithmetic chain and its output buffer.
//   DATA_WIDTH_OUT    : result width used by every chain block
//   ARB_DEPTH_DEFAULT : default entry count of arith_result_buffer
//   clog2()           : ceiling log2 for pointer and level widths
package arith_chain_pkg;

  localparam int unsigned DATA_WIDTH_OUT    = 10;
  localparam int unsigned ARB_DEPTH_DEFAULT = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/arith_result_buffer.sv
// Output buffer behind the pipelined arithmetic chain. It captures the chain's
// valid-qualified result stream (no backpressure) into a first-word-fall-through
// FIFO and hands results to the consumer over valid/ready. Results arriving
// while full are dropped and recorded in a sticky flag and a saturating counter.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_data/valid   : result stream from the chain
//   out_data/valid  : head entry (0 when empty) and non-empty flag
//   out_ready       : consumer accepts the head entry this cycle
//   level, full     : occupancy 0..DEPTH, and level == DEPTH
//   overflow        : sticky drop flag
//   drop_count      : saturating count of dropped results
//   clear_overflow  : synchronous clear of overflow and drop_count
module arith_result_buffer
  import arith_chain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_OUT,
  parameter int unsigned DEPTH      = ARB_DEPTH_DEFAULT,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(DEPTH):0]       level,
  output logic                        full,
  output logic                        overflow,
  output logic [CNT_WIDTH-1:0]        drop_count,
  input  logic                        clear_overflow
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_pop   = !w_empty && out_ready;
  // A pop frees the slot in the same edge, so a full FIFO still takes the write.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  // Storage is deliberately left without reset; level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // A drop in the same cycle as a clear wins: the clear restarts the count at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow) begin
        r_drop_count <= CNT_WIDTH'(1);
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid  = !w_empty;
  assign level      = r_level;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_arith_result_buffer.sv
// Self-checking bench for arith_result_buffer: a queue-based scoreboard models
// occupancy, ordering, drops and the overflow counter cycle by cycle.
module tb_arith_result_buffer;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          full;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          clear_overflow;

  arith_result_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .level         (level),
    .full          (full),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb_q[$];
  logic          m_ovf;
  int unsigned   m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(sb_q.size()));
    check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    check("full", 32'(full), 32'(sb_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), m_cnt);
    if (sb_q.size() != 0) check("out_data", 32'(out_data), 32'(sb_q[0]));
    else                  check("out_data_empty", 32'(out_data), 32'd0);
  endtask

  // One clock cycle: drive inputs, check the current state, advance model and DUT.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic m_full, m_pop, m_push, m_drop;
    in_valid       = v;
    in_data        = d;
    out_ready      = rdy;
    clear_overflow = clr;
    #1;
    check_state();
    m_full = (sb_q.size() == DEPTH);
    m_pop  = (sb_q.size() != 0) && rdy;
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !m_pop;
    if (m_pop) void'(sb_q.pop_front());
    if (m_push) sb_q.push_back(d);
    if (m_drop) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = 1;
      else if (m_cnt != 32'hFFFF) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    check("drain_done", 32'(sb_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b1;
    in_data        = 10'd99;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    model_reset();

    // Reset: outputs zero, in_valid during reset lost.
    @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(drop_count), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;

    // Single result with 1-cycle latency.
    cycle(1'b1, 10'd12, 1'b1, 1'b0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'd12);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_empty", 32'(level), 32'd0);

    // Fill and drop: 10 pushes into 8 entries.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 7) check("fill_full8", 32'(full), 32'd1);
    end
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_cnt", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(out_data), 32'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    drain();

    // Simultaneous push and pop while full.
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, 10'd200, 1'b1, 1'b0);
    check("pp_level", 32'(level), 32'd8);
    check("pp_cnt", 32'(drop_count), 32'd2);
    cycle(1'b1, 10'd201, 1'b0, 1'b0);
    check("cnt3", 32'(drop_count), 32'd3);

    // clear_overflow alone, then together with a drop.
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(drop_count), 32'd0);
    cycle(1'b1, 10'd202, 1'b0, 1'b1);
    check("clrdrop_ovf", 32'(overflow), 32'd1);
    check("clrdrop_cnt", 32'(drop_count), 32'd1);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Pointer wrap at full rate.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, DW'(300 + i), 1'b1, 1'b0);
      check("wrap_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    drain();
    check("wrap_nodrop", 32'(drop_count), 32'd0);

    // Mid-operation reset with level 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(500 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    model_reset();
    in_valid = 1'b1;
    in_data  = 10'd777;
    @(posedge clk);
    #1;
    check("midrst_lost", 32'(level), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(600 + i), 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule
